// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder terminating the EU 16-bit word address bus. A
//   single read or write request is captured in IDLE, held for WAIT_STATES
//   idle cycles, performed on an internal 2**ADDR_BITS x 16 RAM, and
//   completed with a one-cycle rdy pulse.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   req      in   request strobe, only sampled in IDLE
//   we       in   1 = write, 0 = read (captured with req)
//   adr[16]  in   word address (captured with req)
//   din[16]  in   write data (captured with req)
//   dout[16] out  read data, held until the next read completes
//   rdy      out  one-cycle completion pulse
//   busy     out  high from the cycle after capture through the rdy cycle
//   adr_err  out  pulses with rdy when the captured address was out of range
module mem_responder #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] adr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        rdy,
  output logic        busy,
  output logic        adr_err
);

  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   cap;

  // Transaction registers, loaded only on capture; never reset because
  // they are only consumed after a capture has filled them.
  logic [ADDR_BITS-1:0]   adr_q;
  logic                   we_q;
  logic [15:0]            din_q;
  logic                   err_q;

  logic [15:0]            dout_q;
  logic [15:0]            mem_q [DEPTH];

  logic                   oor;
  logic                   mem_we;

  // Anything above the implemented address bits is out of range; the RAM
  // never aliases such an address onto its low bits.
  assign oor = (adr >> ADDR_BITS) != 16'h0000;

  // ---- next-state / control ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cap     = 1'b1;
          cnt_d   = WS_INIT;
          state_d = (WS_INIT != 4'd0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= guards against a stray zero count ever locking up in WAIT
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- request capture ----
  always_ff @(posedge clk) begin
    if (cap) begin
      adr_q <= adr[ADDR_BITS-1:0];
      we_q  <= we;
      din_q <= din;
      err_q <= oor;
    end
  end

  // ---- RAM access ----
  // Reset on the ACCESS edge aborts the write as well.
  assign mem_we = (state_q == S_ACCESS) && we_q && !err_q && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[adr_q] <= din_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= 16'h0000;
    end else if ((state_q == S_ACCESS) && !we_q) begin
      dout_q <= err_q ? 16'h0000 : mem_q[adr_q];
    end
  end

  // ---- outputs ----
  assign dout    = dout_q;
  assign rdy     = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign adr_err = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  // DUT A: default WAIT_STATES=2
  logic        req_a, we_a;
  logic [15:0] adr_a, din_a, dout_a;
  logic        rdy_a, busy_a, err_a;

  // DUT B: WAIT_STATES=0
  logic        req_b, we_b;
  logic [15:0] adr_b, din_b, dout_b;
  logic        rdy_b, busy_b, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(8), .WAIT_STATES(2)) u_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .adr(adr_a), .din(din_a),
    .dout(dout_a), .rdy(rdy_a), .busy(busy_a), .adr_err(err_a)
  );

  mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .adr(adr_b), .din(din_b),
    .dout(dout_b), .rdy(rdy_b), .busy(busy_b), .adr_err(err_b)
  );

  // Runs one transaction starting from IDLE, #1 after an edge. Inputs are
  // scrambled right after capture. Returns busy in the first cycle after
  // capture, the latency in cycles (capture = 0, -1 on timeout), dout and
  // adr_err in the rdy cycle, and rdy one cycle later.
  task automatic xact(input bit b, input logic w, input logic [15:0] a,
                      input logic [15:0] d, output logic busy1, output int lat,
                      output logic [15:0] dq, output logic e, output logic rdy_after);
    logic r;
    if (b) begin req_b = 1'b1; we_b = w; adr_b = a; din_b = d; end
    else   begin req_a = 1'b1; we_a = w; adr_a = a; din_a = d; end
    @(posedge clk); #1;
    if (b) begin req_b = 1'b0; we_b = ~w; adr_b = 16'hFFFF; din_b = 16'hDEAD; end
    else   begin req_a = 1'b0; we_a = ~w; adr_a = 16'hFFFF; din_a = 16'hDEAD; end
    busy1 = b ? busy_b : busy_a;
    lat = 1;
    r = b ? rdy_b : rdy_a;
    while (!r && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      r = b ? rdy_b : rdy_a;
    end
    if (!r) lat = -1;
    dq = b ? dout_b : dout_a;
    e  = b ? err_b : err_a;
    @(posedge clk); #1;
    rdy_after = b ? rdy_b : rdy_a;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy_a !== 1'b0)      begin errors++; $display("FAIL reset_rdy_a got %b exp 0", rdy_a); end
    checks++; if (busy_a !== 1'b0)     begin errors++; $display("FAIL reset_busy_a got %b exp 0", busy_a); end
    checks++; if (err_a !== 1'b0)      begin errors++; $display("FAIL reset_err_a got %b exp 0", err_a); end
    checks++; if (dout_a !== 16'h0000) begin errors++; $display("FAIL reset_dout_a got %h exp 0000", dout_a); end
    checks++; if (rdy_b !== 1'b0 || busy_b !== 1'b0 || dout_b !== 16'h0000)
      begin errors++; $display("FAIL reset_b got rdy=%b busy=%b dout=%h exp 0/0/0000", rdy_b, busy_b, dout_b); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    logic bz, e, ra; int lat; logic [15:0] dq;
    xact(1'b0, 1'b1, 16'h0005, 16'hBEEF, bz, lat, dq, e, ra);
    checks++; if (bz !== 1'b1)    begin errors++; $display("FAIL wr_busy got %b exp 1", bz); end
    checks++; if (lat !== 4)      begin errors++; $display("FAIL wr_latency got %0d exp 4", lat); end
    checks++; if (e !== 1'b0)     begin errors++; $display("FAIL wr_adr_err got %b exp 0", e); end
    checks++; if (dq !== 16'h0000) begin errors++; $display("FAIL wr_dout got %h exp 0000", dq); end
    checks++; if (ra !== 1'b0)    begin errors++; $display("FAIL wr_rdy_pulse got %b exp 0", ra); end
  endtask

  task automatic test_read;
    logic bz, e, ra; int lat; logic [15:0] dq;
    xact(1'b0, 1'b0, 16'h0005, 16'h0000, bz, lat, dq, e, ra);
    checks++; if (lat !== 4)       begin errors++; $display("FAIL rd_latency got %0d exp 4", lat); end
    checks++; if (dq !== 16'hBEEF) begin errors++; $display("FAIL rd_dout got %h exp BEEF", dq); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dout_a !== 16'hBEEF) begin errors++; $display("FAIL rd_dout_hold got %h exp BEEF", dout_a); end
  endtask

  task automatic test_busy_ignore;
    logic bz, e, ra; int lat; logic [15:0] dq; int nrdy; logic [15:0] dr;
    xact(1'b0, 1'b1, 16'h0006, 16'h0000, bz, lat, dq, e, ra);
    // start a read of 5, then try to slip a write in while busy
    req_a = 1'b1; we_a = 1'b0; adr_a = 16'h0005;
    @(posedge clk); #1;
    req_a = 1'b1; we_a = 1'b1; adr_a = 16'h0006; din_a = 16'h1234;
    @(posedge clk); #1;
    req_a = 1'b0;
    nrdy = (rdy_a === 1'b1) ? 1 : 0;
    dr = 16'hxxxx;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rdy_a === 1'b1) begin nrdy++; dr = dout_a; end
    end
    checks++; if (nrdy !== 1)       begin errors++; $display("FAIL busy_rdy_count got %0d exp 1", nrdy); end
    checks++; if (dr !== 16'hBEEF)  begin errors++; $display("FAIL busy_rd_dout got %h exp BEEF", dr); end
    xact(1'b0, 1'b0, 16'h0006, 16'h0000, bz, lat, dq, e, ra);
    checks++; if (dq !== 16'h0000)  begin errors++; $display("FAIL busy_ignored_wr got %h exp 0000", dq); end
  endtask

  task automatic test_out_of_range;
    logic bz, e, ra; int lat; logic [15:0] dq;
    xact(1'b0, 1'b1, 16'h0000, 16'h1111, bz, lat, dq, e, ra);
    xact(1'b0, 1'b1, 16'h0100, 16'hAAAA, bz, lat, dq, e, ra);
    checks++; if (lat !== 4)  begin errors++; $display("FAIL oor_wr_latency got %0d exp 4", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_adr_err got %b exp 1", e); end
    checks++; if (ra !== 1'b0 || err_a !== 1'b0)
      begin errors++; $display("FAIL oor_pulse_len got rdy=%b adr_err=%b exp 0/0", ra, err_a); end
    xact(1'b0, 1'b0, 16'h0000, 16'h0000, bz, lat, dq, e, ra);
    checks++; if (dq !== 16'h1111) begin errors++; $display("FAIL oor_alias got %h exp 1111", dq); end
    checks++; if (e !== 1'b0)      begin errors++; $display("FAIL oor_inrange_err got %b exp 0", e); end
    xact(1'b0, 1'b0, 16'h0100, 16'h0000, bz, lat, dq, e, ra);
    checks++; if (dq !== 16'h0000) begin errors++; $display("FAIL oor_rd_dout got %h exp 0000", dq); end
    checks++; if (e !== 1'b1)      begin errors++; $display("FAIL oor_rd_err got %b exp 1", e); end
    checks++; if (lat !== 4)       begin errors++; $display("FAIL oor_rd_latency got %0d exp 4", lat); end
  endtask

  task automatic test_reset_mid;
    logic bz, e, ra; int lat; logic [15:0] dq; int nrdy;
    xact(1'b0, 1'b1, 16'h0010, 16'h7777, bz, lat, dq, e, ra);
    xact(1'b0, 1'b0, 16'h0010, 16'h0000, bz, lat, dq, e, ra);
    req_a = 1'b1; we_a = 1'b1; adr_a = 16'h0010; din_a = 16'h5555;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy_a !== 1'b0 || busy_a !== 1'b0 || err_a !== 1'b0)
      begin errors++; $display("FAIL mid_reset_ctrl got rdy=%b busy=%b err=%b exp 0/0/0", rdy_a, busy_a, err_a); end
    checks++; if (dout_a !== 16'h0000) begin errors++; $display("FAIL mid_reset_dout got %h exp 0000", dout_a); end
    reset = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rdy_a === 1'b1) nrdy++;
    end
    checks++; if (nrdy !== 0) begin errors++; $display("FAIL mid_reset_rdy got %0d pulses exp 0", nrdy); end
    xact(1'b0, 1'b0, 16'h0010, 16'h0000, bz, lat, dq, e, ra);
    checks++; if (dq !== 16'h7777) begin errors++; $display("FAIL mid_reset_ram got %h exp 7777", dq); end
  endtask

  task automatic test_zero_wait;
    logic bz, e, ra; int lat; logic [15:0] dq;
    int pos[$]; logic idle_gap;
    xact(1'b1, 1'b1, 16'h00FF, 16'hC0DE, bz, lat, dq, e, ra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL zw_wr_latency got %0d exp 2", lat); end
    xact(1'b1, 1'b0, 16'h00FF, 16'h0000, bz, lat, dq, e, ra);
    checks++; if (lat !== 2)       begin errors++; $display("FAIL zw_rd_latency got %0d exp 2", lat); end
    checks++; if (dq !== 16'hC0DE) begin errors++; $display("FAIL zw_rd_dout got %h exp C0DE", dq); end
    // req held high: capture, ACCESS, DONE, IDLE(capture), ...
    req_b = 1'b1; we_b = 1'b0; adr_b = 16'h00FF;
    idle_gap = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (rdy_b === 1'b1) pos.push_back(i);
      if (i == 3) idle_gap = busy_b;
    end
    req_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pos.size() !== 3) begin errors++; $display("FAIL zw_b2b_count got %0d exp 3", pos.size()); end
    else begin
      checks++; if (pos[0] !== 2 || pos[1] !== 5 || pos[2] !== 8)
        begin errors++; $display("FAIL zw_b2b_spacing got %0d,%0d,%0d exp 2,5,8", pos[0], pos[1], pos[2]); end
    end
    checks++; if (idle_gap !== 1'b0) begin errors++; $display("FAIL zw_idle_gap busy got %b exp 0", idle_gap); end
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; adr_a = 16'h0; din_a = 16'h0;
    req_b = 1'b0; we_b = 1'b0; adr_b = 16'h0; din_b = 16'h0;
    test_reset();
    test_write();
    test_read();
    test_busy_ignore();
    test_out_of_range();
    test_reset_mid();
    test_zero_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
